dataflow_perf_profiler: RTL and testbench

Synthesizable, parametrised run-time profiler for HLS ap_ctrl_hs/ap_ctrl_chain sub-blocks and pipelined loops. It replaces simulation-only status dumping with on-chip counters. Each of NUM_CH channels taps one sub-block's start/ready/done/continue handshake plus its loop iteration and stall strobes. Per-channel statistics are read back through a registered read port. It sits beside the kernel top and is driven from the same clock.

---
 rtl/dataflow_perf_profiler.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_dataflow_perf_profiler.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dataflow_perf_profiler.sv
// dataflow_perf_profiler
// ----------------------
// Run-time profiler for HLS ap_ctrl_hs / ap_ctrl_chain sub-blocks and
// pipelined loops. Each of NUM_CH channels follows one sub-block's
// start/done/continue handshake and counts transactions, latency
// (last/min/max), loop iterations, stall cycles and active cycles.
// Statistics are read back through a registered, 1-cycle-latency port.
//
// Optional feature: define DATAFLOW_PERF_PROFILER_HIST_EN to add a
// four-bin latency histogram per channel (rd_sel 8..11).
//
// Ports:
//   clock_i         sole clock
//   reset_i         synchronous, active-high reset
//   finish_i        end-of-run; sticky freeze of all statistics
//   clr_i           synchronous clear of all statistics (FSMs unaffected)
//   ch_start_i      per-channel ap_start
//   ch_ready_i      per-channel ap_ready (reported in the status word only)
//   ch_done_i       per-channel ap_done
//   ch_continue_i   per-channel ap_continue (tie high for ap_ctrl_hs)
//   iter_end_i      per-channel loop iteration completed this cycle
//   stall_i         per-channel loop pipeline stalled this cycle
//   rd_en_i         read request
//   rd_ch_i         channel select
//   rd_sel_i        statistic select
//   rd_data_o       read data (holds its last value between reads)
//   rd_valid_o      read data valid, one cycle after rd_en_i
//   busy_mask_o     channel is running or waiting for continue
//   ovf_mask_o      sticky: a counter of this channel saturated
//   frozen_o        finish has been seen

module dataflow_perf_profiler #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned CH_W    = 4,
    parameter int unsigned HIST_T0 = 16,
    parameter int unsigned HIST_T1 = 64,
    parameter int unsigned HIST_T2 = 256
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              finish_i,
    input  logic              clr_i,
    input  logic [NUM_CH-1:0] ch_start_i,
    input  logic [NUM_CH-1:0] ch_ready_i,
    input  logic [NUM_CH-1:0] ch_done_i,
    input  logic [NUM_CH-1:0] ch_continue_i,
    input  logic [NUM_CH-1:0] iter_end_i,
    input  logic [NUM_CH-1:0] stall_i,
    input  logic              rd_en_i,
    input  logic [CH_W-1:0]   rd_ch_i,
    input  logic [3:0]        rd_sel_i,
    output logic [CNT_W-1:0]  rd_data_o,
    output logic              rd_valid_o,
    output logic [NUM_CH-1:0] busy_mask_o,
    output logic [NUM_CH-1:0] ovf_mask_o,
    output logic              frozen_o
);

    if (NUM_CH < 1 || NUM_CH > 16 || (64'd1 << CH_W) < 64'(NUM_CH) ||
        HIST_T0 > HIST_T1 || HIST_T1 > HIST_T2) begin : g_bad_cfg
        $error("dataflow_perf_profiler: invalid parameter set");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                input logic             en);
        return (en && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
    endfunction

    // True when an increment is requested on a counter already at its limit.
    function automatic logic sat_hit(input logic [CNT_W-1:0] v, input logic en);
        return en && (v == CNT_MAX);
    endfunction

`ifdef DATAFLOW_PERF_PROFILER_HIST_EN
    function automatic logic [1:0] lat_bin(input logic [CNT_W-1:0] lat);
        if (64'(lat) <= 64'(HIST_T0)) return 2'd0;
        if (64'(lat) <= 64'(HIST_T1)) return 2'd1;
        if (64'(lat) <= 64'(HIST_T2)) return 2'd2;
        return 2'd3;
    endfunction
`endif

    // ------------------------------------------------------------------
    // Per-channel handshake FSMs
    // ------------------------------------------------------------------
    state_e            state_q   [NUM_CH];
    state_e            state_d   [NUM_CH];
    logic [CNT_W-1:0]  lat_run_q [NUM_CH];
    logic [CNT_W-1:0]  lat_run_d [NUM_CH];
    logic [CNT_W-1:0]  lat_now   [NUM_CH];
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] complete;

    // The start cycle already counts as busy and as the first latency
    // cycle, so a start seen in IDLE is treated as the first RUN cycle.
    always_comb begin : fsm_comb
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            state_d[c]   = state_q[c];
            lat_run_d[c] = lat_run_q[c];
            lat_now[c]   = sat_inc(lat_run_q[c], 1'b1);
            busy[c]      = 1'b0;
            complete[c]  = 1'b0;
            case (state_q[c])
                S_IDLE: begin
                    if (ch_start_i[c]) begin
                        busy[c]      = 1'b1;
                        lat_run_d[c] = CNT_W'(1);
                        lat_now[c]   = CNT_W'(1);
                        if (ch_done_i[c]) begin
                            complete[c] = 1'b1;
                            state_d[c]  = ch_continue_i[c] ? S_IDLE : S_WAIT;
                        end else begin
                            state_d[c]  = S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    busy[c]      = 1'b1;
                    lat_run_d[c] = sat_inc(lat_run_q[c], 1'b1);
                    if (ch_done_i[c]) begin
                        complete[c] = 1'b1;
                        state_d[c]  = ch_continue_i[c] ? S_IDLE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    busy[c] = 1'b1;
                    if (ch_continue_i[c]) begin
                        state_d[c] = S_IDLE;
                    end
                end
                default: state_d[c] = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
    logic              frozen_q;
    logic              upd;
    logic [NUM_CH-1:0] ovf_q,  ovf_d;
    logic [CNT_W-1:0]  txn_q   [NUM_CH], txn_d   [NUM_CH];
    logic [CNT_W-1:0]  last_q  [NUM_CH], last_d  [NUM_CH];
    logic [CNT_W-1:0]  minl_q  [NUM_CH], minl_d  [NUM_CH];
    logic [CNT_W-1:0]  maxl_q  [NUM_CH], maxl_d  [NUM_CH];
    logic [CNT_W-1:0]  iter_q  [NUM_CH], iter_d  [NUM_CH];
    logic [CNT_W-1:0]  stall_q [NUM_CH], stall_d [NUM_CH];
    logic [CNT_W-1:0]  act_q   [NUM_CH], act_d   [NUM_CH];
`ifdef DATAFLOW_PERF_PROFILER_HIST_EN
    logic [CNT_W-1:0]  hist_q  [NUM_CH][4];
    logic [CNT_W-1:0]  hist_d  [NUM_CH][4];
`endif

    // Anything happening in the finish cycle itself is already discarded.
    assign upd = ~(frozen_q | finish_i);

    always_comb begin : stat_comb
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            txn_d[c]   = txn_q[c];
            last_d[c]  = last_q[c];
            minl_d[c]  = minl_q[c];
            maxl_d[c]  = maxl_q[c];
            iter_d[c]  = iter_q[c];
            stall_d[c] = stall_q[c];
            act_d[c]   = act_q[c];
            ovf_d[c]   = ovf_q[c];
`ifdef DATAFLOW_PERF_PROFILER_HIST_EN
            for (int unsigned b = 0; b < 4; b++) begin
                hist_d[c][b] = hist_q[c][b];
            end
`endif
            if (clr_i) begin
                txn_d[c]   = '0;
                last_d[c]  = '0;
                minl_d[c]  = '1;
                maxl_d[c]  = '0;
                iter_d[c]  = '0;
                stall_d[c] = '0;
                act_d[c]   = '0;
                ovf_d[c]   = 1'b0;
`ifdef DATAFLOW_PERF_PROFILER_HIST_EN
                for (int unsigned b = 0; b < 4; b++) begin
                    hist_d[c][b] = '0;
                end
`endif
            end else if (upd) begin
                txn_d[c]   = sat_inc(txn_q[c],   complete[c]);
                iter_d[c]  = sat_inc(iter_q[c],  iter_end_i[c]);
                stall_d[c] = sat_inc(stall_q[c], stall_i[c]);
                act_d[c]   = sat_inc(act_q[c],   busy[c]);
                ovf_d[c]   = ovf_q[c]
                           | sat_hit(txn_q[c],   complete[c])
                           | sat_hit(iter_q[c],  iter_end_i[c])
                           | sat_hit(stall_q[c], stall_i[c])
                           | sat_hit(act_q[c],   busy[c]);
                if (complete[c]) begin
                    last_d[c] = lat_now[c];
                    if (lat_now[c] < minl_q[c]) minl_d[c] = lat_now[c];
                    if (lat_now[c] > maxl_q[c]) maxl_d[c] = lat_now[c];
                end
`ifdef DATAFLOW_PERF_PROFILER_HIST_EN
                for (int unsigned b = 0; b < 4; b++) begin
                    hist_d[c][b] = sat_inc(hist_q[c][b],
                                           complete[c] && (lat_bin(lat_now[c]) == 2'(b)));
                    ovf_d[c]     = ovf_d[c] |
                                   sat_hit(hist_q[c][b],
                                           complete[c] && (lat_bin(lat_now[c]) == 2'(b)));
                end
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Read multiplexer: sees register contents before this cycle's update
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] rd_mux;
    logic [CNT_W+4:0] status_w;
    logic [CNT_W-1:0] rd_data_q;
    logic             rd_valid_q;

    // Unmatched channel numbers leave rd_mux at zero.
    always_comb begin : rd_comb
        rd_mux   = '0;
        status_w = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (rd_ch_i == CH_W'(c)) begin
                status_w      = '0;
                status_w[4:0] = {frozen_q, ovf_q[c], ch_ready_i[c], state_q[c]};
                case (rd_sel_i)
                    4'd0:    rd_mux = txn_q[c];
                    4'd1:    rd_mux = last_q[c];
                    4'd2:    rd_mux = minl_q[c];
                    4'd3:    rd_mux = maxl_q[c];
                    4'd4:    rd_mux = iter_q[c];
                    4'd5:    rd_mux = stall_q[c];
                    4'd6:    rd_mux = act_q[c];
                    4'd7:    rd_mux = status_w[CNT_W-1:0];
`ifdef DATAFLOW_PERF_PROFILER_HIST_EN
                    4'd8, 4'd9, 4'd10, 4'd11:
                             rd_mux = hist_q[c][rd_sel_i[1:0]];
`endif
                    default: rd_mux = '0;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            frozen_q   <= 1'b0;
            ovf_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                state_q[c]   <= S_IDLE;
                lat_run_q[c] <= '0;
                txn_q[c]     <= '0;
                last_q[c]    <= '0;
                minl_q[c]    <= '1;
                maxl_q[c]    <= '0;
                iter_q[c]    <= '0;
                stall_q[c]   <= '0;
                act_q[c]     <= '0;
`ifdef DATAFLOW_PERF_PROFILER_HIST_EN
                for (int unsigned b = 0; b < 4; b++) begin
                    hist_q[c][b] <= '0;
                end
`endif
            end
        end else begin
            frozen_q   <= frozen_q | finish_i;
            ovf_q      <= ovf_d;
            rd_valid_q <= rd_en_i;
            if (rd_en_i) begin
                rd_data_q <= rd_mux;
            end
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                state_q[c]   <= state_d[c];
                lat_run_q[c] <= lat_run_d[c];
                txn_q[c]     <= txn_d[c];
                last_q[c]    <= last_d[c];
                minl_q[c]    <= minl_d[c];
                maxl_q[c]    <= maxl_d[c];
                iter_q[c]    <= iter_d[c];
                stall_q[c]   <= stall_d[c];
                act_q[c]     <= act_d[c];
`ifdef DATAFLOW_PERF_PROFILER_HIST_EN
                for (int unsigned b = 0; b < 4; b++) begin
                    hist_q[c][b] <= hist_d[c][b];
                end
`endif
            end
        end
    end

    assign rd_data_o   = rd_data_q;
    assign rd_valid_o  = rd_valid_q;
    assign busy_mask_o = busy & {NUM_CH{~reset_i}};
    assign ovf_mask_o  = ovf_q;
    assign frozen_o    = frozen_q;

endmodule

// File: tb/tb_dataflow_perf_profiler.sv
// Bench for dataflow_perf_profiler: directed handshake scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// transaction-level model (latency from recorded start cycle numbers).

module tb_dataflow_perf_profiler;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 32;
    localparam int CH_W   = 4;
    localparam longint MAXV = 64'h0000_0000_FFFF_FFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main DUT signals
    logic              rst, fin, clr;
    logic [NUM_CH-1:0] start, ready, done, cont, iter, stall;
    logic              rd_en;
    logic [CH_W-1:0]   rd_ch;
    logic [3:0]        rd_sel;
    logic [CNT_W-1:0]  rd_data;
    logic              rd_valid;
    logic [NUM_CH-1:0] busy, ovf;
    logic              frozen;

    // narrow-counter DUT signals
    logic       s_rst, s_clr, s_rd_en, s_rd_ch;
    logic [1:0] s_iter;
    logic [3:0] s_rd_sel;
    logic [3:0] s_rd_data;
    logic       s_rd_valid, s_frozen;
    logic [1:0] s_busy, s_ovf;

    dataflow_perf_profiler #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .CH_W(CH_W)) u_dut (
        .clock_i(clk), .reset_i(rst), .finish_i(fin), .clr_i(clr),
        .ch_start_i(start), .ch_ready_i(ready), .ch_done_i(done),
        .ch_continue_i(cont), .iter_end_i(iter), .stall_i(stall),
        .rd_en_i(rd_en), .rd_ch_i(rd_ch), .rd_sel_i(rd_sel),
        .rd_data_o(rd_data), .rd_valid_o(rd_valid),
        .busy_mask_o(busy), .ovf_mask_o(ovf), .frozen_o(frozen)
    );

    dataflow_perf_profiler #(.NUM_CH(2), .CNT_W(4), .CH_W(1)) u_sat (
        .clock_i(clk), .reset_i(s_rst), .finish_i(1'b0), .clr_i(s_clr),
        .ch_start_i(2'b00), .ch_ready_i(2'b00), .ch_done_i(2'b00),
        .ch_continue_i(2'b11), .iter_end_i(s_iter), .stall_i(2'b00),
        .rd_en_i(s_rd_en), .rd_ch_i(s_rd_ch), .rd_sel_i(s_rd_sel),
        .rd_data_o(s_rd_data), .rd_valid_o(s_rd_valid),
        .busy_mask_o(s_busy), .ovf_mask_o(s_ovf), .frozen_o(s_frozen)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Transaction-level model
    // phase: 0 idle, 1 in a transaction, 2 finished but awaiting continue
    // ------------------------------------------------------------------
    int     m_phase [NUM_CH];
    longint m_start [NUM_CH];
    longint m_txn [NUM_CH], m_last [NUM_CH], m_min [NUM_CH], m_max [NUM_CH];
    longint m_iter [NUM_CH], m_stall [NUM_CH], m_act [NUM_CH];
    longint m_hist [NUM_CH][4];
    bit     m_ovf [NUM_CH];
    bit     m_frozen, m_rd_valid, m_started;
    longint m_rd_data;
    longint cyc = 0;

    function automatic longint mread(input int ch, input int sel, input bit rdy);
        if (ch >= NUM_CH) return 0;
        case (sel)
            0: return m_txn[ch];
            1: return m_last[ch];
            2: return m_min[ch];
            3: return m_max[ch];
            4: return m_iter[ch];
            5: return m_stall[ch];
            6: return m_act[ch];
            7: return longint'(m_phase[ch]) + (rdy ? 4 : 0) + (m_ovf[ch] ? 8 : 0)
                      + (m_frozen ? 16 : 0);
`ifdef DATAFLOW_PERF_PROFILER_HIST_EN
            8, 9, 10, 11: return m_hist[ch][sel-8];
`endif
            default: return 0;
        endcase
    endfunction

    task automatic m_clear_stats();
        for (int c = 0; c < NUM_CH; c++) begin
            m_txn[c] = 0; m_last[c] = 0; m_min[c] = MAXV; m_max[c] = 0;
            m_iter[c] = 0; m_stall[c] = 0; m_act[c] = 0; m_ovf[c] = 0;
            for (int b = 0; b < 4; b++) m_hist[c][b] = 0;
        end
    endtask

    function automatic int bin_of(input longint lat);
        if (lat <= 16)  return 0;
        if (lat <= 64)  return 1;
        if (lat <= 256) return 2;
        return 3;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_clear_stats();
            for (int c = 0; c < NUM_CH; c++) m_phase[c] = 0;
            m_frozen = 0; m_rd_valid = 0; m_rd_data = 0; m_started = 1;
        end else if (m_started) begin
            bit upd, rdy, bz, comp;
            longint lat;
            upd = !(m_frozen || fin);
            rdy = (rd_ch < NUM_CH) ? ready[rd_ch[1:0]] : 1'b0;
            if (rd_en) m_rd_data = mread(int'(rd_ch), int'(rd_sel), rdy);
            m_rd_valid = rd_en;
            for (int c = 0; c < NUM_CH; c++) begin
                bz   = (m_phase[c] != 0) || start[c];
                comp = (m_phase[c] == 0 && start[c] && done[c]) || (m_phase[c] == 1 && done[c]);
                lat  = (m_phase[c] == 0) ? 1 : cyc - m_start[c] + 1;
                if (clr) begin
                    m_txn[c] = 0; m_last[c] = 0; m_min[c] = MAXV; m_max[c] = 0;
                    m_iter[c] = 0; m_stall[c] = 0; m_act[c] = 0; m_ovf[c] = 0;
                    for (int b = 0; b < 4; b++) m_hist[c][b] = 0;
                end else if (upd) begin
                    if (comp) begin
                        if (m_txn[c] == MAXV) m_ovf[c] = 1; else m_txn[c]++;
                        m_last[c] = lat;
                        if (lat < m_min[c]) m_min[c] = lat;
                        if (lat > m_max[c]) m_max[c] = lat;
`ifdef DATAFLOW_PERF_PROFILER_HIST_EN
                        if (m_hist[c][bin_of(lat)] == MAXV) m_ovf[c] = 1;
                        else m_hist[c][bin_of(lat)]++;
`endif
                    end
                    if (iter[c])  begin if (m_iter[c]  == MAXV) m_ovf[c] = 1; else m_iter[c]++;  end
                    if (stall[c]) begin if (m_stall[c] == MAXV) m_ovf[c] = 1; else m_stall[c]++; end
                    if (bz)       begin if (m_act[c]   == MAXV) m_ovf[c] = 1; else m_act[c]++;   end
                end
                case (m_phase[c])
                    0: if (start[c]) begin
                           m_start[c] = cyc;
                           m_phase[c] = done[c] ? (cont[c] ? 0 : 2) : 1;
                       end
                    1: if (done[c]) m_phase[c] = cont[c] ? 0 : 2;
                    default: if (cont[c]) m_phase[c] = 0;
                endcase
            end
            if (fin) m_frozen = 1;
        end
        cyc++;
    end

    // compare process: every cycle once the model has seen a reset
    always @(negedge clk) begin
        if (m_started) begin
            logic [NUM_CH-1:0] eb, eo;
            for (int c = 0; c < NUM_CH; c++) begin
                eb[c] = !rst && ((m_phase[c] != 0) || start[c]);
                eo[c] = m_ovf[c];
            end
            chk("busy_mask", 64'(busy), 64'(eb));
            chk("ovf_mask",  64'(ovf),  64'(eo));
            chk("frozen",    64'(frozen),   64'(m_frozen));
            chk("rd_valid",  64'(rd_valid), 64'(m_rd_valid));
            chk("rd_data",   64'(rd_data),  m_rd_data);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input int ch, input int sel, output logic [CNT_W-1:0] v);
        rd_en = 1'b1; rd_ch = CH_W'(ch); rd_sel = 4'(sel);
        step();
        rd_en = 1'b0;
        v = rd_data;
    endtask

    task automatic s_read(input int sel, output logic [3:0] v);
        s_rd_en = 1'b1; s_rd_ch = 1'b0; s_rd_sel = 4'(sel);
        step();
        s_rd_en = 1'b0;
        v = s_rd_data;
    endtask

    task automatic run_txn(input int ch, input int lat);
        start[ch] = 1'b1;
        if (lat == 1) done[ch] = 1'b1;
        step();
        start[ch] = 1'b0; done[ch] = 1'b0;
        if (lat > 1) begin
            repeat (lat - 2) step();
            done[ch] = 1'b1;
            step();
            done[ch] = 1'b0;
        end
    endtask

    task automatic quiet_inputs();
        fin = 0; clr = 0; start = '0; ready = '0; done = '0; cont = '1;
        iter = '0; stall = '0; rd_en = 0; rd_ch = '0; rd_sel = '0;
    endtask

    logic [CNT_W-1:0] v;
    logic [3:0]       sv;

    initial begin
        quiet_inputs();
        rst = 1'b1;
        s_rst = 1'b1; s_clr = 1'b0; s_rd_en = 1'b0; s_rd_ch = 1'b0; s_rd_sel = '0; s_iter = '0;
        repeat (3) step();
        rst = 1'b0; s_rst = 1'b0;
        chk("reset_rd_data", 64'(rd_data), 64'd0);
        chk("reset_rd_valid", 64'(rd_valid), 64'd0);
        do_read(0, 2, v); chk("reset_min_lat", 64'(v), 64'hFFFF_FFFF);

        // channel 0: latency 5, continue high
        start[0] = 1'b1; step(); start[0] = 1'b0;
        repeat (3) step();
        done[0] = 1'b1; step(); done[0] = 1'b0;
        do_read(0, 0, v); chk("ch0_txn",    64'(v), 64'd1);
        do_read(0, 1, v); chk("ch0_last",   64'(v), 64'd5);
        do_read(0, 2, v); chk("ch0_min",    64'(v), 64'd5);
        do_read(0, 3, v); chk("ch0_max",    64'(v), 64'd5);
        do_read(0, 6, v); chk("ch0_active", 64'(v), 64'd5);
        do_read(0, 0, v);
        do_read(NUM_CH, 0, v);
        chk("oor_valid", 64'(rd_valid), 64'd1);
        chk("oor_data",  64'(v), 64'd0);

        // channel 1: done without continue, three cycles waiting
        start[1] = 1'b1; step(); start[1] = 1'b0;
        repeat (2) step();
        done[1] = 1'b1; cont[1] = 1'b0; step(); done[1] = 1'b0;
        do_read(1, 7, v); chk("ch1_status_wait", 64'(v), 64'd2);
        done[1] = 1'b1;
        do_read(1, 1, v); chk("ch1_last", 64'(v), 64'd4);
        done[1] = 1'b0;
        cont[1] = 1'b1; step();
        do_read(1, 6, v); chk("ch1_active", 64'(v), 64'd7);
        do_read(1, 0, v); chk("ch1_txn_done_ignored", 64'(v), 64'd1);
        do_read(1, 7, v); chk("ch1_status_idle", 64'(v), 64'd0);

        // channel 2: latencies 3, 70, 1
        run_txn(2, 3); run_txn(2, 70); run_txn(2, 1);
        do_read(2, 2, v); chk("ch2_min",  64'(v), 64'd1);
        do_read(2, 3, v); chk("ch2_max",  64'(v), 64'd70);
        do_read(2, 1, v); chk("ch2_last", 64'(v), 64'd1);
        do_read(2, 0, v); chk("ch2_txn",  64'(v), 64'd3);
`ifdef DATAFLOW_PERF_PROFILER_HIST_EN
        do_read(2, 8,  v); chk("ch2_bin0", 64'(v), 64'd2);
        do_read(2, 9,  v); chk("ch2_bin1", 64'(v), 64'd0);
        do_read(2, 10, v); chk("ch2_bin2", 64'(v), 64'd1);
        do_read(2, 11, v); chk("ch2_bin3", 64'(v), 64'd0);
`else
        do_read(2, 8, v); chk("ch2_bin0_absent", 64'(v), 64'd0);
`endif

        // narrow counters: saturation and clear
        s_iter[0] = 1'b1; repeat (20) step(); s_iter[0] = 1'b0;
        s_read(4, sv); chk("sat_iter", 64'(sv), 64'd15);
        chk("sat_ovf", 64'(s_ovf), 64'd1);
        s_clr = 1'b1; s_iter[0] = 1'b1; step(); s_clr = 1'b0; s_iter[0] = 1'b0;
        s_read(4, sv); chk("sat_iter_clr", 64'(sv), 64'd0);
        chk("sat_ovf_clr", 64'(s_ovf), 64'd0);
        s_read(2, sv); chk("sat_min_clr", 64'(sv), 64'd15);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            start  = NUM_CH'($urandom & $urandom);
            done   = NUM_CH'($urandom & $urandom);
            cont   = NUM_CH'($urandom | $urandom);
            iter   = NUM_CH'($urandom);
            stall  = NUM_CH'($urandom & $urandom);
            ready  = NUM_CH'($urandom);
            rd_en  = ($urandom_range(0, 2) != 0);
            rd_ch  = ($urandom_range(0, 9) == 0) ? CH_W'($urandom_range(4, 15))
                                                : CH_W'($urandom_range(0, 3));
            rd_sel = 4'($urandom_range(0, 15));
            clr    = ($urandom_range(0, 199) == 0);
            fin    = ($urandom_range(0, 1499) == 0);
            rst    = ($urandom_range(0, 699) == 0);
            step();
        end
        quiet_inputs();
        rst = 1'b1; step(); rst = 1'b0;

        // finish in mid-transaction
        start[3] = 1'b1; step(); start[3] = 1'b0;
        step();
        fin = 1'b1; iter[3] = 1'b1; step(); fin = 1'b0; iter[3] = 1'b0;
        step();
        done[3] = 1'b1; step(); done[3] = 1'b0;
        chk("frozen_set", 64'(frozen), 64'd1);
        do_read(3, 0, v); chk("frozen_txn", 64'(v), 64'd0);
        do_read(3, 7, v); chk("frozen_status", 64'(v), 64'd16);
        do_read(3, 4, v); chk("frozen_iter", 64'(v), 64'd0);

        // reset during RUN
        rst = 1'b1; step(); rst = 1'b0;
        start[0] = 1'b1; step(); start[0] = 1'b0;
        rd_en = 1'b1; step(); rd_en = 1'b0;
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_busy",   64'(busy),     64'd0);
        chk("rst_valid",  64'(rd_valid), 64'd0);
        chk("rst_frozen", 64'(frozen),   64'd0);
        chk("rst_data",   64'(rd_data),  64'd0);
        done[0] = 1'b1; step(); done[0] = 1'b0;
        do_read(0, 0, v); chk("rst_txn_not_counted", 64'(v), 64'd0);

        step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
